maxpool2x2_stream: RTL

- Downstream stage of the 2D convolution processor. Consumes the raster-ordered 16-bit convolution result stream (6x6 per frame by default).
- Applies 2x2 max pooling with stride 2 on the fly and emits a 3x3 pooled stream.
- Uses a half-row line buffer of partial maxima; no full-frame storage.

---
 rtl/conv_pkg.sv | 16 +
 rtl/pool_line_buf.sv | 24 ++
 rtl/maxpool2x2_stream.sv | 89 ++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared constants and helpers for the convolution processor's streaming stages.
package conv_pkg;

  localparam int IMG_W_DEF  = 6;
  localparam int IMG_H_DEF  = 6;
  localparam int DATA_W_DEF = 16;
  localparam int POOL_W     = IMG_W_DEF / 2;
  localparam int POOL_H     = IMG_H_DEF / 2;

  // Unsigned maximum; on a tie either operand is the same value.
  function automatic logic [DATA_W_DEF-1:0] max2(input logic [DATA_W_DEF-1:0] a,
                                                 input logic [DATA_W_DEF-1:0] b);
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-row store of vertical-pair partial maxima: one write port, one combinational read port.
module pool_line_buf #(
  parameter int DEPTH  = 3,
  parameter int DATA_W = 16,
  parameter int AW     = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is not reset: every entry is rewritten by an even row before it is read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/maxpool2x2_stream.sv
// 2x2 stride-2 max pooling over a raster-ordered sample stream, one output per completed block.
module maxpool2x2_stream
  import conv_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              out_valid,
  output logic              frame_done,
  output logic              busy
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PW = IMG_W / 2;
  localparam int AW = (PW > 1) ? $clog2(PW) : 1;

  logic [CW-1:0]     col, eff_col;
  logic [RW-1:0]     row, eff_row;
  logic [DATA_W-1:0] pair, pair_max, lb_rdata;
  logic [AW-1:0]     lb_addr;
  logic              col_last, row_last, pos_first;
  logic              lb_we, completing, busy_r;

  // frame_start zeroes the position seen by a sample arriving in the same cycle.
  assign eff_col   = frame_start ? '0 : col;
  assign eff_row   = frame_start ? '0 : row;
  assign col_last  = (eff_col == CW'(IMG_W - 1));
  assign row_last  = (eff_row == RW'(IMG_H - 1));
  assign pos_first = (eff_col == '0) && (eff_row == '0);

  assign pair_max   = max2(pair, din);
  assign lb_addr    = AW'(eff_col >> 1);
  assign lb_we      = in_valid & eff_col[0] & ~eff_row[0];
  assign completing = in_valid & eff_col[0] & eff_row[0];

  pool_line_buf #(
    .DEPTH (PW),
    .DATA_W(DATA_W),
    .AW    (AW)
  ) u_line_buf (
    .clk  (clk),
    .we   (lb_we),
    .waddr(lb_addr),
    .wdata(pair_max),
    .raddr(lb_addr),
    .rdata(lb_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      pair       <= '0;
      dout       <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      if (in_valid) begin
        col <= col_last ? '0 : eff_col + 1'b1;
        if (col_last) row <= row_last ? '0 : eff_row + 1'b1;
        else          row <= eff_row;
        if (!eff_col[0]) pair <= din;
      end else if (frame_start) begin
        col <= '0;
        row <= '0;
      end

      out_valid  <= completing;
      frame_done <= completing & col_last & row_last;
      if (completing) dout <= max2(lb_rdata, pair_max);

      if (in_valid && pos_first)        busy_r <= 1'b1;
      else if (frame_start || frame_done) busy_r <= 1'b0;
    end
  end

  // busy drops in the frame_done cycle unless the next frame's first sample is being accepted.
  assign busy = busy_r & ~(frame_done & ~(in_valid & pos_first));

endmodule
